// File: rtl/multi_producer_fsm.sv
// Multi-channel stimulus producer for the stall/flush pipeline harness.
// Each channel i issues the integer stream i, i+STRIDE, i+2*STRIDE, ... (mod 2^DATA_W),
// honours its own stall input, raises a one-cycle flush every FLUSH_PERIOD issued
// items and, when MAX_ITEMS is nonzero, stops after MAX_ITEMS items and reports done.
module multi_producer_fsm #(
    parameter int NUM_CH       = 2,
    parameter int DATA_W       = 32,
    parameter int STRIDE       = NUM_CH,
    parameter int FLUSH_PERIOD = 32,
    parameter int MAX_ITEMS    = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        stall,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        flush,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0]       MAX_W    = 32'(MAX_ITEMS);
    localparam logic [31:0]       FP_W     = 32'(FLUSH_PERIOD);
    localparam logic [DATA_W-1:0] STRIDE_W = DATA_W'(STRIDE);

    state_t            state_reg;
    state_t            state_next;
    logic              done_reg;
    logic [NUM_CH-1:0] reached;
    logic              all_reached;
    logic              rearm;

    assign all_reached = &reached;
    // Leaving DONE returns every channel to its power-on stream position.
    assign rearm       = (state_reg == DONE) && !enable;
    assign done        = done_reg;

    // State register; done is registered from the next state so it rises on DONE entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_next == DONE);
        end
    end

    // Next-state logic: enable low always wins over completion while running.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (enable) state_next = RUN;
            end
            RUN: begin
                if (!enable)                          state_next = IDLE;
                else if (MAX_ITEMS != 0 && all_reached) state_next = DONE;
            end
            DONE: begin
                if (!enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : ch_g
            logic [DATA_W-1:0] data_reg;
            logic [DATA_W-1:0] next_val_reg;
            logic [31:0]       issued_reg;
            logic [31:0]       period_reg;
            logic              valid_reg;
            logic              due_reg;
            logic              flush_reg;
            logic              issue;
            logic              period_hit;

            assign reached[gi] = (MAX_ITEMS != 0) && (issued_reg == MAX_W);
            assign issue       = (state_reg == RUN) && enable && !stall[gi] && !reached[gi];
            // period_reg counts issues modulo FLUSH_PERIOD; hitting the top means this
            // issue lands on a nonzero multiple of the period.
            assign period_hit  = (FLUSH_PERIOD != 0) && (period_reg == FP_W - 32'd1);

            assign ch_data[gi*DATA_W +: DATA_W] = data_reg;
            assign in_valid[gi]                 = valid_reg;
            assign flush[gi]                    = flush_reg;

            // Per-channel issue path; the flush is staged through due_reg so it appears
            // one edge after the issue that completed the period, regardless of stall/enable.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    data_reg     <= DATA_W'(gi);
                    next_val_reg <= DATA_W'(gi);
                    issued_reg   <= 32'd0;
                    period_reg   <= 32'd0;
                    valid_reg    <= 1'b0;
                    due_reg      <= 1'b0;
                    flush_reg    <= 1'b0;
                end else begin
                    valid_reg <= issue;
                    due_reg   <= issue && period_hit;
                    flush_reg <= due_reg;
                    if (rearm) begin
                        data_reg     <= DATA_W'(gi);
                        next_val_reg <= DATA_W'(gi);
                        issued_reg   <= 32'd0;
                        period_reg   <= 32'd0;
                    end else if (issue) begin
                        data_reg     <= next_val_reg;
                        next_val_reg <= next_val_reg + STRIDE_W;
                        issued_reg   <= issued_reg + 32'd1;
                        period_reg   <= period_hit ? 32'd0 : period_reg + 32'd1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_multi_producer_fsm.sv
// Self-checking bench for multi_producer_fsm: three instances cover the free-running
// stream with stall/flush/pause/reset, the MAX_ITEMS done path, and narrow-width wrap.
module tb_multi_producer_fsm;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Instance A: two channels, flush every 4 items, runs forever.
    logic        enable_a;
    logic [1:0]  stall_a;
    logic [63:0] ch_data_a;
    logic [1:0]  in_valid_a, flush_a;
    logic        done_a;

    multi_producer_fsm #(.NUM_CH(2), .DATA_W(32), .FLUSH_PERIOD(4), .MAX_ITEMS(0)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable_a), .stall(stall_a),
        .ch_data(ch_data_a), .in_valid(in_valid_a), .flush(flush_a), .done(done_a)
    );

    // Instance B: two channels, stop after 5 items each.
    logic        enable_b;
    logic [1:0]  stall_b;
    logic [63:0] ch_data_b;
    logic [1:0]  in_valid_b, flush_b;
    logic        done_b;

    multi_producer_fsm #(.NUM_CH(2), .DATA_W(32), .FLUSH_PERIOD(0), .MAX_ITEMS(5)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable_b), .stall(stall_b),
        .ch_data(ch_data_b), .in_valid(in_valid_b), .flush(flush_b), .done(done_b)
    );

    // Instance C: one 4-bit channel with stride 3.
    logic        enable_c;
    logic [0:0]  stall_c;
    logic [3:0]  ch_data_c;
    logic [0:0]  in_valid_c, flush_c;
    logic        done_c;

    multi_producer_fsm #(.NUM_CH(1), .DATA_W(4), .STRIDE(3), .FLUSH_PERIOD(0), .MAX_ITEMS(0)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .enable(enable_c), .stall(stall_c),
        .ch_data(ch_data_c), .in_valid(in_valid_c), .flush(flush_c), .done(done_c)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    // Scoreboard for instance A: one expected output record per clock edge.
    typedef struct packed {
        logic [1:0]  v;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  f;
    } rec_t;

    rec_t        sb_a[$];
    logic [31:0] ma_nv[2];
    logic [31:0] ma_data[2];
    int          ma_issued[2];
    logic [1:0]  ma_due;
    logic        ma_run;

    task automatic model_reset_a();
        for (int i = 0; i < 2; i++) begin
            ma_nv[i]     = 32'(i);
            ma_data[i]   = 32'(i);
            ma_issued[i] = 0;
        end
        ma_due = 2'b00;
        ma_run = 1'b0;
        sb_a.delete();
    endtask

    // Drive A's inputs for the coming edge and push what the outputs must be after it.
    task automatic drive_a(input logic en, input logic [1:0] st);
        rec_t       r;
        logic [1:0] due_n;
        enable_a = en;
        stall_a  = st;
        r.f   = ma_due;
        r.v   = 2'b00;
        due_n = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (ma_run && en && !st[i]) begin
                ma_data[i] = ma_nv[i];
                ma_nv[i]   = ma_nv[i] + 32'd2;
                ma_issued[i]++;
                r.v[i] = 1'b1;
                if (ma_issued[i] % 4 == 0) due_n[i] = 1'b1;
            end
        end
        ma_due = due_n;
        r.d0   = ma_data[0];
        r.d1   = ma_data[1];
        ma_run = en;
        sb_a.push_back(r);
    endtask

    task automatic compare_a();
        rec_t r;
        if (sb_a.size() == 0) return;
        r = sb_a.pop_front();
        check("a_valid", 64'(in_valid_a), 64'(r.v));
        check("a_ch0", 64'(ch_data_a[31:0]), 64'(r.d0));
        check("a_ch1", 64'(ch_data_a[63:32]), 64'(r.d1));
        check("a_flush", 64'(flush_a), 64'(r.f));
    endtask

    task automatic cycle_a(input logic en, input logic [1:0] st, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            compare_a();
            drive_a(en, st);
        end
    endtask

    logic [31:0] exp_b0[$], exp_b1[$];
    logic [3:0]  exp_c[$];

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last0_cyc, last1_cyc, done_cyc;
        logic [31:0] e;
        logic [3:0]  ec;

        reset_n  = 1'b0;
        enable_a = 1'b0; stall_a = 2'b00;
        enable_b = 1'b0; stall_b = 2'b00;
        enable_c = 1'b0; stall_c = 1'b0;
        model_reset_a();
        repeat (2) @(negedge clk);

        check("rst_valid", 64'(in_valid_a), 64'd0);
        check("rst_flush", 64'(flush_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_data", ch_data_a, 64'h0000_0001_0000_0000);

        // Free run, stall ch0 for three edges, run on, pause, resume.
        reset_n = 1'b1;
        drive_a(1'b1, 2'b00);
        cycle_a(1'b1, 2'b00, 4);
        cycle_a(1'b1, 2'b01, 3);
        cycle_a(1'b1, 2'b00, 8);
        cycle_a(1'b0, 2'b00, 3);
        cycle_a(1'b1, 2'b10, 2);
        cycle_a(1'b1, 2'b00, 4);

        // Asynchronous reset in the middle of a running stream.
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(in_valid_a), 64'd0);
        check("arst_flush", 64'(flush_a), 64'd0);
        check("arst_done", 64'(done_a), 64'd0);
        check("arst_data", ch_data_a, 64'h0000_0001_0000_0000);
        model_reset_a();
        @(negedge clk);
        reset_n = 1'b1;
        drive_a(1'b1, 2'b00);
        cycle_a(1'b1, 2'b00, 5);
        @(negedge clk);
        compare_a();
        enable_a = 1'b0;

        // MAX_ITEMS=5 with ch1 stalled for two edges.
        for (int i = 0; i < 5; i++) begin
            exp_b0.push_back(32'(2 * i));
            exp_b1.push_back(32'(2 * i + 1));
        end
        last0_cyc = 0; last1_cyc = 0; done_cyc = 0;
        @(negedge clk);
        enable_b = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (in_valid_b[0]) begin
                last0_cyc = cyc;
                if (exp_b0.size() > 0) begin
                    e = exp_b0.pop_front();
                    check("b_ch0", 64'(ch_data_b[31:0]), 64'(e));
                end else check("b_ch0_extra", 64'(in_valid_b[0]), 64'd0);
            end
            if (in_valid_b[1]) begin
                last1_cyc = cyc;
                if (exp_b1.size() > 0) begin
                    e = exp_b1.pop_front();
                    check("b_ch1", 64'(ch_data_b[63:32]), 64'(e));
                end else check("b_ch1_extra", 64'(in_valid_b[1]), 64'd0);
            end
            if (done_b) begin
                if (done_cyc == 0) done_cyc = cyc;
                check("b_valid_in_done", 64'(in_valid_b), 64'd0);
            end else if (exp_b1.size() > 0) begin
                check("b_done_early", 64'(done_b), 64'd0);
            end
            stall_b = (cyc == 1 || cyc == 2) ? 2'b10 : 2'b00;
            if (done_cyc != 0 && cyc >= done_cyc + 2) break;
        end
        check("b_done_seen", 64'(done_b), 64'd1);
        check("b_left0", 64'(exp_b0.size()), 64'd0);
        check("b_left1", 64'(exp_b1.size()), 64'd0);
        check("b_last0_cyc", 64'(last0_cyc), 64'd6);
        check("b_last1_cyc", 64'(last1_cyc), 64'd8);
        check("b_done_cyc", 64'(done_cyc), 64'd9);
        check("b_flush_never", 64'(flush_b), 64'd0);

        enable_b = 1'b0;
        @(negedge clk);
        check("b_rearm_done", 64'(done_b), 64'd0);
        check("b_rearm_data", ch_data_b, 64'h0000_0001_0000_0000);
        enable_b = 1'b1;
        @(negedge clk);
        check("b_restart_idle", 64'(in_valid_b), 64'd0);
        @(negedge clk);
        check("b_restart_valid", 64'(in_valid_b), 64'd3);
        check("b_restart_data", ch_data_b, 64'h0000_0001_0000_0000);
        enable_b = 1'b0;

        // 4-bit, stride 3: wrap modulo 16.
        ec = 4'd0;
        for (int i = 0; i < 7; i++) begin
            exp_c.push_back(ec);
            ec = ec + 4'd3;
        end
        @(negedge clk);
        enable_c = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (in_valid_c[0]) begin
                if (exp_c.size() > 0) begin
                    ec = exp_c.pop_front();
                    check("c_data", 64'(ch_data_c), 64'(ec));
                end
            end
            if (exp_c.size() == 0) break;
        end
        check("c_left", 64'(exp_c.size()), 64'd0);
        enable_c = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
